// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES       = 4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, and drives the IF/ID pipeline register toward decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned           WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0]  RESET_PC  = RESET_PC_DEFAULT[WORD_SIZE-1:0],
  parameter logic [WORD_SIZE-1:0]  NOP_INSTR = NOP_INSTR_DEFAULT[WORD_SIZE-1:0]
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 pc_src,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic                 flush_ifid,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic [WORD_SIZE-1:0] ifid_pc,
  output logic [WORD_SIZE-1:0] ifid_instr,
  output logic                 ifid_valid
);

  // Handshake: a request transfers on any rising edge where imem_req && imem_ready;
  // its single response is the first imem_rvalid at least one cycle later.

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] req_pc_q, req_pc_d;
  logic                 kill_q, kill_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [WORD_SIZE-1:0] hold_pc_q, hold_pc_d;
  logic [WORD_SIZE-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_SIZE-1:0] ifid_pc_q, ifid_pc_d;
  logic [WORD_SIZE-1:0] ifid_instr_q, ifid_instr_d;
  logic                 ifid_valid_q, ifid_valid_d;

  logic                 accept;
  logic                 load;
  logic [WORD_SIZE-1:0] load_pc;
  logic [WORD_SIZE-1:0] load_instr;
  logic [WORD_SIZE-1:0] next_seq_pc;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 unused_target_bits;

  assign imem_req           = (state_q == S_REQ);
  assign imem_addr          = pc_q;
  assign accept             = imem_req && imem_ready;
  assign next_seq_pc        = req_pc_q + WORD_SIZE'(INSTR_BYTES);
  assign redirect_pc        = {branch_target[WORD_SIZE-1:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    load         = 1'b0;
    load_pc      = req_pc_q;
    load_instr   = imem_rdata;

    case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall) begin
            load    = 1'b1;
            pc_d    = next_seq_pc;
            state_d = S_REQ;
          end else begin
            hold_valid_d = 1'b1;
            hold_pc_d    = req_pc_q;
            hold_instr_d = imem_rdata;
            pc_d         = next_seq_pc;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          load         = 1'b1;
          load_pc      = hold_pc_q;
          load_instr   = hold_instr_q;
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides whatever the normal path decided this cycle.
    if (pc_src) begin
      pc_d         = redirect_pc;
      hold_valid_d = 1'b0;
      load         = 1'b0;
      case (state_q)
        S_REQ: begin
          if (accept) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    if (pc_src || flush_ifid) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (load) begin
      ifid_pc_d    = load_pc;
      ifid_instr_d = load_instr;
      ifid_valid_d = 1'b1;
    end else if (!stall) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifndef SYNTHESIS
  // A response still in flight across reset may land in the first cycle after it.
  a_rvalid_only_when_waiting : assert property (
    @(posedge clk) disable iff (rst)
    (imem_rvalid && !$past(rst)) |-> (state_q == S_WAIT)
  ) else $error("imem_rvalid outside S_WAIT (state=%0d)", state_q);
`endif

endmodule
